// File: rtl/mac_unit_if.sv
// Operand/result handshake bundle for mac_unit.
// master drives operands and out_ready; slave is the MAC itself.
interface mac_unit_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int COUNT_WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_a;
    logic [DATA_WIDTH-1:0]  in_b;
    logic                   in_signed;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_WIDTH-1:0]   out_acc;
    logic [COUNT_WIDTH-1:0] out_count;
    logic                   out_sat;

    modport master (
        output in_valid, in_a, in_b, in_signed, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_sat
    );
endinterface

// File: rtl/mac_unit.sv
// Two-stage pipelined multiply-accumulate with valid/ready in and out.
// Define MAC_SAT_EN to saturate the accumulator instead of wrapping.
module mac_unit #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int COUNT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mac_unit_if.slave   bus
);

    localparam int PW = 2 * DATA_WIDTH;

    logic stall;
    logic accept;

    logic                   s1_valid;
    logic                   s1_last;
    logic                   s1_signed;
    logic [PW-1:0]          p_reg;

    logic [ACC_WIDTH-1:0]   acc;
    logic [COUNT_WIDTH-1:0] cnt;
    logic                   first_beat;

    logic                   out_valid_q;
    logic [ACC_WIDTH-1:0]   out_acc_q;
    logic [COUNT_WIDTH-1:0] out_count_q;

    logic signed [PW-1:0]   prod_s;
    logic [PW-1:0]          prod_u;
    logic [PW-1:0]          prod;

    logic [ACC_WIDTH-1:0]   acc_base;
    logic [ACC_WIDTH-1:0]   ext;
    logic [ACC_WIDTH-1:0]   sum;

`ifdef MAC_SAT_EN
    logic [ACC_WIDTH:0]     sum_wide;
    logic                   clamp;
    logic                   sat_sticky;
    logic                   out_sat_q;
`endif

    // The whole pipeline freezes while a finished result waits downstream.
    assign stall        = out_valid_q & ~bus.out_ready;
    assign accept       = bus.in_valid & ~stall;
    assign bus.in_ready = ~stall;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        prod_s = PW'($signed(bus.in_a)) * PW'($signed(bus.in_b));
        prod_u = PW'(bus.in_a) * PW'(bus.in_b);
        prod   = bus.in_signed ? $unsigned(prod_s) : prod_u;
    end

    // NOTE: sequential state uses non-blocking assignments only; all pipeline
    // registers are small flops, so each one is cleared explicitly on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_signed <= 1'b0;
            p_reg     <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                p_reg     <= prod;
                s1_last   <= bus.in_last;
                s1_signed <= bus.in_signed;
            end
        end
    end

    always_comb begin
        acc_base = first_beat ? '0 : acc;
        ext      = s1_signed ? ACC_WIDTH'($signed(p_reg)) : ACC_WIDTH'(p_reg);
`ifdef MAC_SAT_EN
        sum_wide = {1'b0, acc_base} + {1'b0, ext};
        sum      = sum_wide[ACC_WIDTH-1:0];
        clamp    = 1'b0;
        if (s1_signed) begin
            // Signed overflow: both addends agree in sign but the sum does not.
            if ((acc_base[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1])) begin
                clamp = 1'b1;
                sum   = ext[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else if (sum_wide[ACC_WIDTH]) begin
            clamp = 1'b1;
            sum   = '1;
        end
`else
        sum = acc_base + ext;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            first_beat  <= 1'b1;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
`ifdef MAC_SAT_EN
            sat_sticky  <= 1'b0;
            out_sat_q   <= 1'b0;
`endif
        end else if (!stall) begin
            // Not stalled means any held result is being consumed this edge.
            out_valid_q <= 1'b0;
            if (s1_valid) begin
                if (s1_last) begin
                    out_valid_q <= 1'b1;
                    out_acc_q   <= sum;
                    out_count_q <= cnt + 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                    first_beat  <= 1'b1;
`ifdef MAC_SAT_EN
                    out_sat_q   <= sat_sticky | clamp;
                    sat_sticky  <= 1'b0;
`endif
                end else begin
                    acc        <= sum;
                    cnt        <= cnt + 1'b1;
                    first_beat <= 1'b0;
`ifdef MAC_SAT_EN
                    sat_sticky <= sat_sticky | clamp;
`endif
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_count = out_count_q;
`ifdef MAC_SAT_EN
    assign bus.out_sat   = out_sat_q;
`else
    assign bus.out_sat   = 1'b0;
`endif

endmodule

// File: doc/mac_unit.md
Name: mac_unit

Overview:
Pipelined, parametrised multiply-accumulate unit for the accelerator PE array. It is the successor to the single-cycle registered multiplier.
- Streams operand pairs through a valid/ready handshake and accumulates products across a vector delimited by in_last.
- Emits the dot-product result, with a beat count, through a valid/ready output register.
- Supports per-beat signed or unsigned operands and full-pipeline backpressure.

Parameters:
DATA_WIDTH, 8, operand width (a, b)
ACC_WIDTH, 32, accumulator/result width; must be >= 2*DATA_WIDTH
COUNT_WIDTH, 8, beat-counter width; vectors longer than 2^COUNT_WIDTH-1 beats wrap the count only

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat this cycle
in_a  input  DATA_WIDTH  operand A
in_b  input  DATA_WIDTH  operand B
in_signed  input  1  1 = two's-complement operands for this beat, 0 = unsigned
in_last  input  1  final beat of the current vector
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  downstream accepts result
out_acc  output  ACC_WIDTH  accumulated dot product
out_count  output  COUNT_WIDTH  number of beats in the vector
out_sat  output  1  saturation occurred in this vector (MAC_SAT_EN only, else 0)

Behaviour:
- Reset (rst_n=0 at a rising edge): all pipeline valids cleared, accumulator and beat counter cleared. out_valid=0, out_acc=0, out_count=0, out_sat=0. A partial vector in flight is discarded. in_ready=1 in the first cycle after reset.
- Stall = out_valid & ~out_ready. in_ready = ~stall (combinational).
  - While stalled, every pipeline register holds.
  - No beat is accepted; in_valid may stay high.
- Accept: a beat is accepted when in_valid & in_ready.
- Stage 1 (edge of acceptance): p_reg <= in_a*in_b as a 2*DATA_WIDTH-bit product.
  - Signed multiply if in_signed, else unsigned.
  - s1_valid, s1_last and s1_signed are registered alongside.
- Stage 2 (next non-stalled edge with s1_valid):
  - Product extension to ACC_WIDTH: sign-extended if s1_signed, else zero-extended.
  - sum = (first_beat ? 0 : acc) + ext_product. first_beat is set by reset and after each last beat.
  - Non-last beat: acc <= sum; cnt <= cnt+1 (cnt = 0 at the first beat).
  - Last beat: out_acc <= sum, out_count <= cnt+1, out_valid <= 1. Then acc <= 0, cnt <= 0, first_beat <= 1.
- Latency: a last beat accepted at edge E0 gives out_valid=1 after edge E0+1, i.e. 2 cycles from the cycle it is presented.
- Throughput: 1 beat/clock. A single-beat vector (in_valid & in_last every cycle) gives one result per clock when out_ready=1.
- Output handshake:
  - out_valid stays 1 and out_acc/out_count/out_sat stay stable until out_valid & out_ready.
  - A new result may load on the same edge the old one is consumed, since stall=0 when out_ready=1.
  - out_valid drops only if no new last beat completes on that edge.
- Overflow, default: the accumulator wraps modulo 2^ACC_WIDTH.
- Simultaneous events:
  - rst_n=0 overrides handshake activity.
  - out_ready sampled together with an arriving result: consume and load on the same edge.
- in_signed can change per beat; mixed-sign vectors are legal and accumulate per-beat extended products.

Optional Feature:
MAC_SAT_EN
- Defined: stage 2 saturates instead of wrapping.
  - Signed beat: overflow is detected from operand and sum sign bits. Clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - Unsigned beat: carry-out clamps to all-ones.
  - A clamped value continues accumulating from the clamp.
  - A sticky per-vector flag is set on any clamp, copied to out_sat with the result, and cleared at vector start.
- Undefined: wrap-around arithmetic; out_sat tied to 0; no saturation logic synthesised.

Test Plan:
1. Unsigned vector a={1,2,3}, b={4,5,6}, last on 3rd beat, out_ready=1 -> one out_valid pulse: out_acc=32, out_count=3, arriving 2 cycles after the last beat.
2. Signed single beat a=8'hFD (-3), b=8'h05, in_signed=1, last=1 -> out_acc=32'hFFFFFFF1 (-15), out_count=1. Same operands with in_signed=0 -> out_acc=32'h000004F1 (1265).
3. Backpressure: continuous single-beat vectors a=i, b=1 (i=1..6), out_ready low for 3 cycles after the first result -> in_ready=0 during the stall, out_acc=1 held stable, then results 2..6 in order with none lost or duplicated.
4. Overflow, ACC_WIDTH=16: unsigned beats 255*255 twice, then last -> default out_acc=16'hFC02, out_sat=0. With MAC_SAT_EN: out_acc=16'hFFFF, out_sat=1. The next vector {1*1} gives out_acc=1, out_sat=0.
5. Reset mid-vector: two beats of a=10, b=10 accepted, rst_n=0 for one cycle, then vector {2*3, last} -> out_acc=6, out_count=1, with no residue from the discarded partial sum.
